// File: rtl/noc_multi_port_connector_pkg.sv
// noc_multi_port_connector_pkg: shared widths and state encodings for the multi-port connector.
// Contents: Noc_Data_Width (default flit payload width), chk_state_t (per-channel
// packet checker states) and arb_state_t (output arbiter states).
package noc_multi_port_connector_pkg;
    localparam int Noc_Data_Width = 8;
    typedef enum logic {CHK_IDLE, CHK_IN_PKT} chk_state_t;
    typedef enum logic {ARB_SEL, ARB_LOCK} arb_state_t;
endpackage

// File: rtl/noc_multi_port_connector_if.sv
// noc_multi_port_connector_if: flit links of the connector, bundled as one interface.
// Signals: per-channel input link (in_valid, in_ready, in_flit, in_is_header, in_is_tail),
// single output link (out_valid, out_ready, out_flit, out_is_header, out_is_tail,
// out_src_ch) and the sticky per-channel proto_err flags.
// Modports: slave = connector side, master = injector/router side.
interface noc_multi_port_connector_if
    import noc_multi_port_connector_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = Noc_Data_Width
);
    localparam int CH_W = $clog2(NUM_CH);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_flit;
    logic [NUM_CH-1:0]        in_is_header;
    logic [NUM_CH-1:0]        in_is_tail;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_flit;
    logic                     out_is_header;
    logic                     out_is_tail;
    logic [CH_W-1:0]          out_src_ch;
    logic [NUM_CH-1:0]        proto_err;
    modport slave (
        input  in_valid, in_flit, in_is_header, in_is_tail, out_ready,
        output in_ready, out_valid, out_flit, out_is_header, out_is_tail, out_src_ch, proto_err
    );
    modport master (
        output in_valid, in_flit, in_is_header, in_is_tail, out_ready,
        input  in_ready, out_valid, out_flit, out_is_header, out_is_tail, out_src_ch, proto_err
    );
endinterface

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: synchronous FIFO for one channel's flits with count-based full/empty.
// Ports: noc_clk, rst (sync, active-high), push/wdata (write side, caller never pushes
// when full), pop/rdata (rdata is the head entry, caller never pops when empty),
// full, empty.
module noc_flit_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         noc_clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    always_ff @(posedge noc_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge noc_clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
    assign rdata = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/noc_multi_port_connector.sv
// noc_multi_port_connector: merges NUM_CH packet links onto one output, whole packets at a time.
// Ports: noc_clk (sole clock), rst (sync, active-high), bus (slave modport):
//   in_* per-channel flit links, out_* merged output link with out_src_ch naming the
//   source channel, proto_err sticky per-channel protocol-violation flags.
// Each channel has a flit FIFO fed through a header/tail checker; a packet-locked
// round-robin arbiter drains one FIFO until its tail flit leaves.
module noc_multi_port_connector
    import noc_multi_port_connector_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = Noc_Data_Width,
    parameter int FIFO_DEPTH = 4
) (
    input logic noc_clk,
    input logic rst,
    noc_multi_port_connector_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int W    = DATA_W + 2;
    logic [NUM_CH-1:0] full, empty, accept, write, viol, pop, err_q;
    logic [W-1:0] head [NUM_CH];
    logic [W-1:0] head_g;
    chk_state_t chk_q [NUM_CH];
    chk_state_t chk_d [NUM_CH];
    arb_state_t arb_q, arb_d;
    logic [CH_W-1:0] grant_q, last_q, sel, idx;
    logic found, out_v, pop_hs;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign bus.in_ready = rst ? '0 : ~full;
    assign accept       = bus.in_valid & bus.in_ready;

    // Idle channels only take headers; in-packet channels only take non-headers.
    always_comb begin
        write = '0;
        viol  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            write[i] = accept[i] && (chk_q[i] == CHK_IDLE ? bus.in_is_header[i] : !bus.in_is_header[i]);
            viol[i]  = accept[i] && !write[i];
            chk_d[i] = write[i] ? (bus.in_is_tail[i] ? CHK_IDLE : CHK_IN_PKT) : chk_q[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        noc_flit_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .noc_clk (noc_clk),
            .rst     (rst),
            .push    (write[g]),
            .wdata   ({bus.in_is_header[g], bus.in_is_tail[g], bus.in_flit[g*DATA_W +: DATA_W]}),
            .pop     (pop[g]),
            .rdata   (head[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
    end

    // Scan from farthest to nearest so the last hit is the first channel after last_q.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last_q) + k) % NUM_CH);
            if (!empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        head_g = head[grant_q];
        out_v  = !rst && arb_q == ARB_LOCK && !empty[grant_q];
        pop_hs = out_v && bus.out_ready;
        pop    = pop_hs ? NUM_CH'(1) << grant_q : '0;
        arb_d  = arb_q == ARB_SEL ? (found ? ARB_LOCK : ARB_SEL) : (pop_hs && head_g[W-2] ? ARB_SEL : ARB_LOCK);
    end

    always_ff @(posedge noc_clk) begin
        if (rst) begin
            arb_q   <= ARB_SEL;
            grant_q <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            err_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) chk_q[i] <= CHK_IDLE;
        end else begin
            arb_q <= arb_d;
            err_q <= err_q | viol;
            for (int i = 0; i < NUM_CH; i++) chk_q[i] <= chk_d[i];
            if (arb_q == ARB_SEL && found) begin
                grant_q <= sel;
                last_q  <= sel;
            end
        end
    end

    assign bus.out_valid     = out_v;
    assign bus.out_flit      = out_v ? head_g[DATA_W-1:0] : '0;
    assign bus.out_is_header = out_v & head_g[W-1];
    assign bus.out_is_tail   = out_v & head_g[W-2];
    assign bus.out_src_ch    = rst ? '0 : grant_q;
    assign bus.proto_err     = rst ? '0 : err_q;
endmodule

// File: doc/noc_multi_port_connector.md
Name: noc_multi_port_connector

Overview:
- Parametrised successor to the single-port connector: terminates NUM_CH flit-level valid/ready input links, each with its own flit FIFO and packet-protocol checker.
- Multiplexes whole packets onto one output link using a packet-locked round-robin arbiter.
- Sits between local injection ports (PEs/DMAs) and a router local port.
- Never interleaves flits of different packets on the output.

Parameters:
- NUM_CH, 4, number of input channels (2..8).
- DATA_W, `Noc_Data_Width, flit payload width.
- FIFO_DEPTH, 4, flits per channel FIFO (power of two, >= 2).
- CH_W, $clog2(NUM_CH), derived; width of the channel index.

Ports:
- noc_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel flit valid.
- in_ready  out  NUM_CH  per-channel flit ready.
- in_flit  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_is_header  in  NUM_CH  flit is the first flit of a packet.
- in_is_tail  in  NUM_CH  flit is the last flit of a packet.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream ready.
- out_flit  out  DATA_W  output flit.
- out_is_header  out  1  header marker for the output flit.
- out_is_tail  out  1  tail marker for the output flit.
- out_src_ch  out  CH_W  source channel of the current output flit.
- proto_err  out  NUM_CH  sticky per-channel protocol-violation flag.

Behaviour:
- Interface: one clock, noc_clk; reset rst is synchronous and active-high.
- Reset: all FIFOs are emptied; checkers go to IDLE; the arbiter goes to ARB with last_grant = NUM_CH-1, so channel 0 has first priority.
- Output values during reset: in_ready = 0, out_valid = 0, proto_err = 0, out_src_ch = 0.
- out_flit, out_is_header and out_is_tail read as 0 when out_valid = 0.
- Reset asserted mid-packet discards all buffered and in-flight flits. No partial packet is completed after reset.
- in_ready[i] = !full[i], driven from the registered occupancy count only. It has no combinational path from out_ready.
- A flit is accepted when in_valid[i] && in_ready[i]. While in_ready[i] = 0, a push to a full FIFO is impossible, even if a pop occurs in the same cycle.
- Per-channel checker has two states, IDLE and IN_PKT, and runs on accepted flits:
  - IDLE + header + tail: written; single-flit packet; stays IDLE.
  - IDLE + header: written; goes to IN_PKT.
  - IDLE + non-header: dropped (not written); proto_err[i] is set.
  - IN_PKT + header: dropped; proto_err[i] is set; stays IN_PKT.
  - IN_PKT + tail: written; goes to IDLE.
- proto_err is cleared only by rst.
- FIFO: simultaneous push and pop is allowed at any occupancy below full. Pointers wrap modulo FIFO_DEPTH. An occupancy counter of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- Arbiter has two states, ARB and LOCK:
  - In ARB, it searches channels last_grant+1 ... last_grant+NUM_CH (mod NUM_CH) for the first non-empty FIFO.
  - On a hit, it registers grant and last_grant and goes to LOCK. The decision takes one cycle; out_valid = 0 in ARB.
  - In LOCK, out_valid = !empty[grant], and the output fields come from the head of FIFO[grant].
  - An out_valid && out_ready handshake pops FIFO[grant].
  - A handshake on a tail flit returns the arbiter to ARB.
  - A granted FIFO that runs empty mid-packet deasserts out_valid and keeps the lock until the tail arrives.
- Latency: input handshake at edge k, arbiter idle, gives out_valid = 1 in the cycle after edge k+1, so the minimum is 2 cycles.
- There is one idle bubble between consecutive packets on the output.
- Once out_valid is high it stays high, with stable flit and markers, until out_ready; this follows from FIFO head semantics.
- The arbiter runs independently of input acceptance. A channel may accept flits while another channel holds the lock.

Decomposition:
- Shared package/include (extend Noc_parameters.v): Noc_Data_Width, checker state encodings (CHK_IDLE, CHK_IN_PKT) and arbiter state encodings (ARB_SEL, ARB_LOCK).
- Natural sub-module: noc_flit_fifo. It is a sync FIFO of DATA_W+2 bits (flit, header, tail) with a count-based full/empty and one instance per channel.
- The checker and arbiter remain in the top module.

Test Plan:
- Single-flit packet (header = tail = 1, flit 0xA5) on channel 2 at cycle 0, out_ready = 1 → out_valid at cycle 2 with out_flit = 0xA5, out_src_ch = 2, header = tail = 1.
- Channels 0 and 1 each send a 3-flit packet in the same cycle → ch0's three flits come out contiguously, then one bubble, then ch1's three flits. No interleaving occurs.
- out_ready held 0 while channel 0 sends 5 flits with FIFO_DEPTH = 4 → in_ready[0] falls after the 4th accept. The 5th flit is accepted the cycle after out_ready rises. All 5 flits are delivered in order.
- Channel 3 sends body flit 0x11 while IDLE → proto_err[3] = 1 and the flit never appears on the output. A subsequent valid packet on channel 3 is still forwarded, and proto_err[3] remains 1.
- Round-robin fairness with all 4 channels continuously loaded with 2-flit packets → grant order is 0, 1, 2, 3, 0, … .
- rst pulsed mid-packet while channel 1 is locked with 2 flits buffered → next cycle out_valid = 0 and all FIFOs are empty. A new packet on channel 0 is forwarded first.
